delay_line_ctrl: RTL and testbench

Sequencer for the echo/delay-line sample memory: accepts one audio sample per handshake, maintains the circular write pointer over `T` words, and issues the read of the delayed sample. It mixes the delayed sample back with gain and saturation, writes the result (or the dry sample) into the line, and emits the wet sample. It sits between the audio input/output path and the dual-port delay memory wrapper: read on port 1, write on port 2.

---
 rtl/delay_pkg.sv | 32 +++
 rtl/echo_mix.sv | 44 ++++
 rtl/delay_line_ctrl.sv | 157 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types, widths and the 42-bit to 32-bit saturation helper for the
// echo/delay-line sequencer.
package delay_pkg;

  localparam int SAMPLE_W = 32;
  localparam int GAIN_W   = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    MIX  = 3'd3,
    WR   = 3'd4
  } state_t;

  localparam logic signed [41:0] SAT_MAX = 42'sd2147483647;
  localparam logic signed [41:0] SAT_MIN = -42'sd2147483648;

  // Clip a 42-bit signed sum to the signed 32-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat32(input logic signed [41:0] s);
    logic signed [SAMPLE_W-1:0] r;
    if (s > SAT_MAX) begin
      r = 32'sh7FFF_FFFF;
    end else if (s < SAT_MIN) begin
      r = 32'sh8000_0000;
    end else begin
      r = s[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_mix.sv
// Echo mixer: y = sat(x + ((z * gain) >>> 8)), or y = x when bypassed.
// The result is registered on the cycle en is high.
module echo_mix
  import delay_pkg::*;
(
  input  logic                clk,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] x,
  input  logic [SAMPLE_W-1:0] z,
  input  logic [GAIN_W-1:0]   gain,
  input  logic                bypass,
  output logic [SAMPLE_W-1:0] y
);

  logic signed [SAMPLE_W-1:0] x_p0;
  logic signed [SAMPLE_W-1:0] z_p0;
  logic signed [40:0]         z_ext_p0;
  logic signed [40:0]         g_ext_p0;
  logic signed [40:0]         prod_p0;
  logic signed [40:0]         echo_p0;
  logic signed [41:0]         sum_p0;
  logic signed [SAMPLE_W-1:0] y_p1;

  // Multiply, scale by 1/256 (floor) and add the dry sample.
  always_comb begin
    x_p0     = $signed(x);
    z_p0     = $signed(z);
    z_ext_p0 = 41'(z_p0);
    g_ext_p0 = $signed(41'({1'b0, gain}));
    prod_p0  = z_ext_p0 * g_ext_p0;
    echo_p0  = prod_p0 >>> 8;
    sum_p0   = 42'(x_p0) + 42'(echo_p0);
  end

  // ---- stage boundary p0 -> p1: saturated (or bypassed) result ----
  always_ff @(posedge clk) begin
    if (en) begin
      y_p1 <= bypass ? x_p0 : sat32(sum_p0);
    end
  end

  assign y = y_p1;

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line sequencer: accepts one sample per handshake, reads the delayed
// word from memory port 1, mixes it back through echo_mix, writes the line
// on port 2 and emits the wet sample.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int B      = 15,
  parameter int T      = 20000,
  parameter int RD_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [SAMPLE_W-1:0] IN_SAMPLE,
  input  logic [B-1:0]        DELAY,
  input  logic [GAIN_W-1:0]   GAIN,
  input  logic                FB_EN,
  input  logic                BYPASS,
  output logic                OUT_VALID,
  output logic [SAMPLE_W-1:0] OUT_SAMPLE,
  output logic [B-1:0]        MEM_ADDR1,
  input  logic [SAMPLE_W-1:0] MEM_DO1,
  output logic [B-1:0]        MEM_ADDR2,
  output logic                MEM_WE,
  output logic [SAMPLE_W-1:0] MEM_DI
);

  localparam logic [B:0]   T_EXT   = (B+1)'(T);
  localparam logic [B:0]   TM1_EXT = (B+1)'(T-1);
  localparam logic [7:0]   WAIT_LAST = 8'(RD_LAT-2);

  state_t state;
  state_t state_nxt;

  logic [7:0]          wait_cnt;
  logic [B-1:0]        wp;
  logic [B:0]          fill;
  logic [SAMPLE_W-1:0] out_hold;

  logic [SAMPLE_W-1:0] x_p0;
  logic [B-1:0]        d_p0;
  logic [GAIN_W-1:0]   gain_p0;
  logic                fb_p0;
  logic                byp_p0;

  logic                accept;
  logic                wr_live;
  logic [B-1:0]        d_clamp;
  logic [B-1:0]        ra;
  logic [SAMPLE_W-1:0] z_sel;
  logic [SAMPLE_W-1:0] y;

  assign accept  = (state == IDLE) && IN_VALID && !RST;
  assign wr_live = (state == WR) && !RST;

  // Clamp the requested delay into [1, T-1].
  always_comb begin
    d_clamp = DELAY;
    if (DELAY == '0) begin
      d_clamp = B'(1);
    end else if ({1'b0, DELAY} > TM1_EXT) begin
      d_clamp = B'(T-1);
    end
  end

  // Read address behind the write pointer, wrapping modulo T.
  always_comb begin
    if (wp >= d_p0) begin
      ra = wp - d_p0;
    end else begin
      ra = B'({1'b0, wp} + T_EXT - {1'b0, d_p0});
    end
  end

  // Locations not yet written since reset read back as silence.
  always_comb begin
    z_sel = MEM_DO1;
    if (fill < {1'b0, d_p0}) begin
      z_sel = '0;
    end
  end

  // ---- stage boundary: request latched at accept ----
  always_ff @(posedge CLK) begin
    if (accept) begin
      x_p0    <= IN_SAMPLE;
      d_p0    <= d_clamp;
      gain_p0 <= GAIN;
      fb_p0   <= FB_EN;
      byp_p0  <= BYPASS;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for IDLE -> RD -> WAIT -> MIX -> WR -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID) state_nxt = RD;
      RD:      state_nxt = (RD_LAT > 1) ? WAIT : MIX;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = MIX;
      MIX:     state_nxt = WR;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts the extra read-latency cycles spent in WAIT.
  always_ff @(posedge CLK) begin
    if (RST || state == RD) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Write pointer, fill level and held output advance on each committed write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp       <= '0;
      fill     <= '0;
      out_hold <= '0;
    end else if (state == WR) begin
      wp       <= (wp == B'(T-1)) ? '0 : wp + 1'b1;
      fill     <= (fill == T_EXT) ? fill : fill + 1'b1;
      out_hold <= y;
    end
  end

  echo_mix u_mix (
    .clk    (CLK),
    .en     (state == MIX),
    .x      (x_p0),
    .z      (z_sel),
    .gain   (gain_p0),
    .bypass (byp_p0),
    .y      (y)
  );

  assign IN_READY   = (state == IDLE) && !RST;
  assign MEM_ADDR1  = ((state == RD || state == WAIT || state == MIX) && !RST) ? ra : '0;
  assign MEM_WE     = wr_live;
  assign MEM_ADDR2  = wr_live ? wp : '0;
  assign MEM_DI     = wr_live ? (fb_p0 ? y : x_p0) : '0;
  assign OUT_VALID  = wr_live;
  assign OUT_SAMPLE = wr_live ? y : out_hold;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomised bench for delay_line_ctrl with a two-cycle-latency memory
// model and a sample-history reference model.
module tb_delay_line_ctrl;

  localparam int B      = 8;
  localparam int T      = 200;
  localparam int RD_LAT = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [31:0]   IN_SAMPLE = '0;
  logic [B-1:0]  DELAY = '0;
  logic [7:0]    GAIN = '0;
  logic          FB_EN = 1'b0;
  logic          BYPASS = 1'b0;
  logic          OUT_VALID;
  logic [31:0]   OUT_SAMPLE;
  logic [B-1:0]  MEM_ADDR1;
  logic [31:0]   MEM_DO1;
  logic [B-1:0]  MEM_ADDR2;
  logic          MEM_WE;
  logic [31:0]   MEM_DI;

  delay_line_ctrl #(.B(B), .T(T), .RD_LAT(RD_LAT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_SAMPLE  (IN_SAMPLE),
    .DELAY      (DELAY),
    .GAIN       (GAIN),
    .FB_EN      (FB_EN),
    .BYPASS     (BYPASS),
    .OUT_VALID  (OUT_VALID),
    .OUT_SAMPLE (OUT_SAMPLE),
    .MEM_ADDR1  (MEM_ADDR1),
    .MEM_DO1    (MEM_DO1),
    .MEM_ADDR2  (MEM_ADDR2),
    .MEM_WE     (MEM_WE),
    .MEM_DI     (MEM_DI)
  );

  always #5 CLK = ~CLK;

  // Dual-port memory: two-cycle registered read, write on port 2.
  logic [31:0] mem [T];
  logic [31:0] rd_p1;
  logic        mem_seeded = 1'b0;
  always @(posedge CLK) begin
    if (!mem_seeded) begin
      for (int i = 0; i < T; i++) mem[i] <= $urandom();
      mem_seeded <= 1'b1;
    end else if (MEM_WE) begin
      mem[MEM_ADDR2] <= MEM_DI;
    end
    rd_p1   <= mem[MEM_ADDR1];
    MEM_DO1 <= rd_p1;
  end

  // Reference model: every word written since reset, in order.
  longint hist[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  function automatic longint rnd32();
    logic signed [31:0] r;
    r = $urandom();
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!IN_READY && k < 20) begin
      @(negedge CLK);
      k++;
    end
    ok = IN_READY;
    if (!ok) chk("ready_timeout", IN_READY, 1);
  endtask

  // One full transaction; called at a negedge, returns at the cycle after WR.
  task automatic send(input longint x, input int dl, input int g, input bit fb,
                      input bit byp, output longint obs);
    int     d, wa, ra, nn;
    longint z, p, y, wrv;
    bit     ok;
    IN_SAMPLE = x[31:0];
    DELAY     = dl[B-1:0];
    GAIN      = g[7:0];
    FB_EN     = fb;
    BYPASS    = byp;
    IN_VALID  = 1'b1;
    obs = 0;
    wait_ready(ok);
    if (!ok) begin
      IN_VALID = 1'b0;
      return;
    end
    nn  = hist.size();
    d   = (dl < 1) ? 1 : ((dl > T-1) ? T-1 : dl);
    z   = (nn >= d) ? hist[nn-d] : 0;
    p   = (z * g) >>> 8;
    y   = byp ? x : sat(x + p);
    wrv = fb ? y : x;
    wa  = nn % T;
    ra  = (wa - d + T) % T;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (k < 4) begin
        chk("rd_addr", MEM_ADDR1, ra);
        chk("busy_ready", IN_READY, 0);
        chk("early_valid", OUT_VALID, 0);
        chk("early_we", MEM_WE, 0);
        IN_VALID  = 1'($urandom_range(0, 1));
        IN_SAMPLE = $urandom();
        DELAY     = B'($urandom());
        GAIN      = 8'($urandom());
        FB_EN     = 1'($urandom_range(0, 1));
        BYPASS    = 1'($urandom_range(0, 1));
      end else begin
        chk("out_valid", OUT_VALID, 1);
        chk("mem_we", MEM_WE, 1);
        chk("wr_addr", MEM_ADDR2, wa);
        chk("wr_data", $signed(MEM_DI), wrv);
        chk("out_sample", $signed(OUT_SAMPLE), y);
        obs = $signed(OUT_SAMPLE);
        IN_VALID = 1'b0;
      end
    end
    hist.push_back(wrv);
    @(negedge CLK);
    chk("ready_again", IN_READY, 1);
    chk("valid_pulse", OUT_VALID, 0);
    chk("out_hold", $signed(OUT_SAMPLE), y);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("rst_ready", IN_READY, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr1", MEM_ADDR1, 0);
    chk("rst_addr2", MEM_ADDR2, 0);
    chk("rst_out", OUT_SAMPLE, 0);
    chk("rst_di", MEM_DI, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", IN_READY, 1);
    hist.delete();
  endtask

  // Reset raised at cycle k_rst of a transaction (4 = the WR cycle).
  task automatic rst_in_op(input int k_rst);
    bit ok;
    IN_SAMPLE = 32'h1234_5678;
    DELAY     = B'(1);
    GAIN      = 8'd200;
    FB_EN     = 1'b0;
    BYPASS    = 1'b0;
    IN_VALID  = 1'b1;
    wait_ready(ok);
    for (int k = 1; k <= k_rst; k++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
    if (k_rst == 4) chk("wr_before_rst", OUT_VALID, 1);
    RST = 1'b1;
    #1;
    chk("rst_wr_we", MEM_WE, 0);
    chk("rst_wr_valid", OUT_VALID, 0);
    chk("rst_wr_ready", IN_READY, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_op_ready", IN_READY, 1);
    chk("rst_op_out", OUT_SAMPLE, 0);
    hist.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint o;
    longint xr;
    do_reset();

    // First sample is dry; then an impulse echo at half gain.
    send(100, 3, 128, 0, 0, o);  chk("first_dry", o, 100);
    send(0, 3, 128, 0, 0, o);    chk("s2", o, 0);
    send(0, 3, 128, 0, 0, o);    chk("s3", o, 0);
    send(0, 3, 128, 0, 0, o);    chk("s4_echo", o, 50);
    send(0, 3, 128, 0, 0, o);    chk("s5", o, 0);
    send(0, 3, 128, 0, 0, o);    chk("s6", o, 0);

    // Run past the pointer wrap with d=5.
    for (int i = 0; i < T + 2; i++) begin
      send(rnd32(), 5, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0, o);
    end

    // Delay clamps at both ends.
    send(rnd32(), 255, 200, 0, 0, o);
    send(rnd32(), 0, 255, 0, 0, o);

    // Saturation, positive and negative.
    send(64'sd2147483647, 1, 0, 0, 0, o);
    send(64'sd2147483632, 1, 255, 0, 0, o);   chk("sat_pos", o, 64'sd2147483647);
    send(-64'sd2147483648, 1, 0, 0, 0, o);
    send(-64'sd2147483632, 1, 255, 0, 0, o);  chk("sat_neg", o, -64'sd2147483648);

    // Bypass, then feedback writes the wet value.
    send(1234, 1, 255, 0, 1, o);  chk("bypass", o, 1234);
    send(1000, 1, 128, 1, 0, o);  chk("fb_wet", o, 1617);
    send(0, 1, 128, 0, 0, o);     chk("fb_echo", o, 808);

    // Reset during WR and during WAIT; first output afterwards is dry.
    rst_in_op(4);
    xr = rnd32();
    send(xr, 1, 255, 0, 0, o);    chk("dry_after_rst", o, xr);
    send(rnd32(), 2, 255, 1, 0, o);
    rst_in_op(2);
    xr = rnd32();
    send(xr, 1, 128, 0, 0, o);    chk("dry_after_abort", o, xr);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      int dl;
      longint x;
      dl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0:       x = 64'sd2147483647;
        1:       x = -64'sd2147483648;
        default: x = rnd32();
      endcase
      send(x, dl, $urandom_range(0, 255), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), o);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
